lfsr_checker: RTL and testbench

- Receive-side counterpart of the LFSR random-bit generator: consumes the serial pseudo-random bit stream, self-synchronises to it, then flags every bit that deviates from the expected sequence.
- Sits at the far end of any link or loopback carrying generator output.
- Gives the on-board bit-error check; no simulator bench is needed to use it.

---
 rtl/lfsr_checker.sv | 120 ++++++++++++
 tb/tb_lfsr_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to an LFSR bit stream, then
// flags each bit that deviates from the predicted sequence.
module lfsr_checker #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      TAPS      = 8'hB8,
  parameter int unsigned           SYNC_BITS = 16,
  parameter int unsigned           WINDOW    = 32,
  parameter int unsigned           LOSS_ERRS = 8,
  parameter int unsigned           COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               locked,
  output logic               error,
  output logic [COUNT_W-1:0] error_count,
  output logic [1:0]         state
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(SYNC_BITS + 1);
  localparam int unsigned FRAME_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ERRS_W  = $clog2(LOSS_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_BITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(WINDOW - 1);
  localparam logic [ERRS_W-1:0]  ERRS_LOSS  = ERRS_W'(LOSS_ERRS);

  logic [1:0]         st;
  logic [WIDTH-1:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [MATCH_W-1:0] match;
  logic [FRAME_W-1:0] frame;
  logic [ERRS_W-1:0]  frame_errs;

  logic               expected;
  logic               mism;
  logic [ERRS_W-1:0]  errs_next;

  always_comb begin
    expected  = ^(hist & TAPS);
    mism      = bit_in ^ expected;
    errs_next = frame_errs + ERRS_W'(mism);
  end

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= HUNT;
      hist        <= '0;
      fill        <= '0;
      match       <= '0;
      frame       <= '0;
      frame_errs  <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
    end else begin
      error <= 1'b0;
      if (bit_valid) begin
        case (st)
          HUNT: begin
            hist <= {hist[WIDTH-2:0], bit_in};
            fill <= fill + FILL_W'(1);
            if (fill == FILL_LAST) begin
              st    <= VERIFY;
              match <= '0;
            end
          end
          VERIFY: begin
            hist <= {hist[WIDTH-2:0], bit_in};
            // an all-zero history predicts zeros forever, so it never counts
            if (!mism && hist != '0) begin
              match <= match + MATCH_W'(1);
              if (match == MATCH_LAST) begin
                st         <= LOCKED;
                locked     <= 1'b1;
                frame      <= '0;
                frame_errs <= '0;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            // flywheel: feed back the prediction so a bad bit cannot propagate
            hist <= {hist[WIDTH-2:0], expected};
            if (mism) begin
              error <= 1'b1;
              if (error_count != '1)
                error_count <= error_count + COUNT_W'(1);
            end
            if (errs_next == ERRS_LOSS) begin
              st         <= HUNT;
              locked     <= 1'b0;
              fill       <= '0;
              frame      <= '0;
              frame_errs <= '0;
            end else if (frame == FRAME_LAST) begin
              frame      <= '0;
              frame_errs <= '0;
            end else begin
              frame      <= frame + FRAME_W'(1);
              frame_errs <= errs_next;
            end
          end
          default: st <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: reference generator drives the stream and
// per-cycle expectations flow through a scoreboard queue.
module tb_lfsr_checker;

  localparam logic [7:0] TAPS = 8'hB8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        locked, error;
  logic [15:0] error_count;
  logic [1:0]  state;
  logic        locked4, error4;
  logic [3:0]  count4;
  logic [1:0]  state4;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH(8), .TAPS(8'hB8), .SYNC_BITS(16), .WINDOW(32),
    .LOSS_ERRS(8), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked), .error(error), .error_count(error_count), .state(state)
  );

  lfsr_checker #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked4), .error(error4), .error_count(count4), .state(state4)
  );

  typedef struct packed {
    logic       err;
    logic       lock;
    logic [1:0] st;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  logic [7:0]  g;
  logic [15:0] r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference generator: same recurrence as the checker predicts
  function automatic logic gen_bit();
    logic nb;
    nb = ^(g & TAPS);
    g  = {g[6:0], nb};
    return nb;
  endfunction

  // independent source for the loss-of-lock test
  function automatic logic rnd_bit();
    r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r[0];
  endfunction

  // k = valid bits consumed since HUNT began on a clean stream
  function automatic exp_t clean_exp(input int k);
    exp_t e;
    e.err  = 1'b0;
    e.lock = (k >= 24);
    e.st   = (k < 8) ? 2'd0 : ((k < 24) ? 2'd1 : 2'd2);
    return e;
  endfunction

  task automatic step(input logic b, input logic v, input exp_t e, input string tag);
    exp_t x;
    bit_in    = b;
    bit_valid = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({tag, " error"},  {31'd0, error},  {31'd0, x.err});
    check({tag, " locked"}, {31'd0, locked}, {31'd0, x.lock});
    check({tag, " state"},  {30'd0, state},  {30'd0, x.st});
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("reset locked", {31'd0, locked}, 32'd0);
    check("reset error",  {31'd0, error},  32'd0);
    check("reset count",  {16'd0, error_count}, 32'd0);
    check("reset state",  {30'd0, state},  32'd0);
    check("reset count4", {28'd0, count4}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic b, rb, gb, mism, lost;
    int   j, errs, nerr;

    // lock from reset on a continuous stream
    do_reset();
    g = 8'h01;
    for (int k = 1; k <= 300; k++) step(gen_bit(), 1'b1, clean_exp(k), "lock");
    check("lock count", {16'd0, error_count}, 32'd0);

    // gapped stream: valid on every third cycle
    do_reset();
    g = 8'h01;
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, 1'b0, clean_exp(k - 1), "gap idle");
      step(1'b1, 1'b0, clean_exp(k - 1), "gap idle");
      step(gen_bit(), 1'b1, clean_exp(k), "gap");
    end
    check("gap count", {16'd0, error_count}, 32'd0);

    // single inverted bit after lock
    do_reset();
    g = 8'h01;
    for (int k = 1; k <= 300; k++) begin
      b = gen_bit();
      e = clean_exp(k);
      if (k == 100) begin
        b     = ~b;
        e.err = 1'b1;
      end
      step(b, 1'b1, e, "single");
    end
    check("single count", {16'd0, error_count}, 32'd1);

    // stuck-at lines never lock
    do_reset();
    for (int k = 1; k <= 200; k++) step(1'b0, 1'b1, clean_exp(k > 23 ? 23 : k), "stuck0");
    do_reset();
    for (int k = 1; k <= 200; k++) step(1'b1, 1'b1, clean_exp(k > 23 ? 23 : k), "stuck1");

    // loss of lock under a foreign stream, then relock
    do_reset();
    g = 8'h01;
    r = 16'hACE1;
    for (int k = 1; k <= 64; k++) step(gen_bit(), 1'b1, clean_exp(k), "preloss");
    j    = 40;
    errs = 0;
    lost = 1'b0;
    for (int n = 0; n < 64 && !lost; n++) begin
      rb   = rnd_bit();
      gb   = gen_bit();
      mism = rb ^ gb;
      e.err = mism;
      if (errs + int'(mism) == 8) lost = 1'b1;
      else if (j % 32 == 31)      errs = 0;
      else                        errs = errs + int'(mism);
      e.lock = ~lost;
      e.st   = lost ? 2'd0 : 2'd2;
      step(rb, 1'b1, e, "loss");
      j++;
    end
    check("loss seen", {31'd0, lost}, 32'd1);
    for (int k = 1; k <= 40; k++) step(gen_bit(), 1'b1, clean_exp(k), "relock");

    // counter saturation with 20 isolated errors, then async reset
    do_reset();
    g    = 8'h01;
    nerr = 0;
    for (int k = 1; k <= 240; k++) begin
      b = gen_bit();
      e = clean_exp(k);
      if (k >= 50 && k % 10 == 0) begin
        b     = ~b;
        e.err = 1'b1;
        nerr++;
      end
      step(b, 1'b1, e, "sat");
    end
    check("sat count16", {16'd0, error_count}, nerr);
    check("sat count4",  {28'd0, count4}, 32'd15);
    check("sat locked4", {31'd0, locked4}, 32'd1);
    check("sat error4",  {31'd0, error4}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async locked", {31'd0, locked}, 32'd0);
    check("async error",  {31'd0, error},  32'd0);
    check("async count",  {16'd0, error_count}, 32'd0);
    check("async state",  {30'd0, state},  32'd0);
    check("async locked4", {31'd0, locked4}, 32'd0);
    check("async error4",  {31'd0, error4}, 32'd0);
    check("async count4",  {28'd0, count4}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int k = 1; k <= 30; k++) step(gen_bit(), 1'b1, clean_exp(k), "fresh");
    check("fresh locked4", {31'd0, locked4}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
